// File: rtl/ctrl_event_arbiter_pkg.sv
// Shared types for the control-event capture path: event codes, widths and the
// event record handed to downstream consumers.
package ctrl_evt_pkg;

    localparam int TS_W_DEF = 12;
    localparam int CH_W     = 2;

    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_RISE = 2'b01,
        EV_FALL = 2'b10
    } ev_code_e;

    typedef struct packed {
        logic [CH_W-1:0]     ch;
        ev_code_e            code;
        logic [TS_W_DEF-1:0] ts;
    } ev_t;

    function automatic ev_code_e edge_code(input logic is_rise);
        return is_rise ? EV_RISE : EV_FALL;
    endfunction

endpackage

// File: rtl/ctrl_event_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index over N requesters; the priority
// pointer only moves when the requester actually takes the grant.
module rr_arbiter
    import ctrl_evt_pkg::*;
#(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_req,
    input  logic            i_accept,
    output logic [N-1:0]    o_grant,
    output logic [CH_W-1:0] o_grant_idx,
    output logic            o_grant_vld
);

    logic [CH_W-1:0] r_last;
    logic [N-1:0]    w_grant;
    logic [CH_W-1:0] w_idx;
    logic [CH_W-1:0] w_cand;
    logic            w_vld;

    // Scan starts one past the last winner so every requester is served in turn.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_grant = '0;
        w_idx   = '0;
        w_cand  = '0;
        w_vld   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_cand = CH_W'((int'(r_last) + k) % N);
            if (!w_vld && i_req[w_cand]) begin
                w_vld          = 1'b1;
                w_idx          = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= CH_W'(N - 1);
        end else if (i_accept && w_vld) begin
            r_last <= w_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_vld;

endmodule

// File: rtl/ctrl_event_arbiter.sv
// Captures edges on level control inputs, timestamps them, buffers one event per
// channel and serialises them round-robin onto a single valid/ready port.
module ctrl_event_arbiter
    import ctrl_evt_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ctrl_in,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [CH_W-1:0]   ev_ch,
    output logic [1:0]        ev_code,
    output logic [TS_W-1:0]   ev_time,
    output logic [NUM_CH-1:0] overflow,
    output logic              busy
);

    logic [NUM_CH-1:0] r_s1, r_s2, r_p;
    logic [TS_W-1:0]   r_cnt;
    logic [NUM_CH-1:0] r_full;
    ev_code_e          r_slot_code [NUM_CH];
    logic [TS_W-1:0]   r_slot_time [NUM_CH];
    logic              r_valid;
    logic [CH_W-1:0]   r_ch;
    ev_code_e          r_code;
    logic [TS_W-1:0]   r_time;
    logic [NUM_CH-1:0] r_ovf;

    logic [NUM_CH-1:0] w_rise, w_fall, w_edge;
    logic [NUM_CH-1:0] w_grant, w_take;
    logic [CH_W-1:0]   w_grant_idx;
    logic              w_grant_vld;
    logic              w_load;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_p  <= '0;
        end else begin
            r_s1 <= ctrl_in;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_p;
    assign w_fall = ~r_s2 & r_p;
    assign w_edge = w_rise | w_fall;

    // Cycles since reset release; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + TS_W'(1);
        end
    end

    rr_arbiter #(
        .N (NUM_CH)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req       (r_full),
        .i_accept    (w_load),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // Output register refills while its current event is being accepted.
    assign w_load = w_grant_vld & (~r_valid | ev_ready);
    assign w_take = w_grant & {NUM_CH{w_load}};

    always_ff @(posedge clk) begin
        // NOTE: slot storage is reset as well, since buffered events must vanish on reset.
        if (!rst) begin
            r_full <= '0;
            r_ovf  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_slot_code[i] <= EV_NONE;
                r_slot_time[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_edge[i]) begin
                    // A slot being drained this cycle can take the new edge immediately.
                    if (!r_full[i] || w_take[i]) begin
                        r_full[i]      <= 1'b1;
                        r_slot_code[i] <= edge_code(w_rise[i]);
                        r_slot_time[i] <= r_cnt;
                    end else begin
                        r_ovf[i] <= 1'b1;
                    end
                end else if (w_take[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_code  <= EV_NONE;
            r_time  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ch    <= w_grant_idx;
            r_code  <= r_slot_code[w_grant_idx];
            r_time  <= r_slot_time[w_grant_idx];
        end else if (ev_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ev_valid = r_valid;
    assign ev_ch    = r_ch;
    assign ev_code  = r_code;
    assign ev_time  = r_time;
    assign overflow = r_ovf;
    assign busy     = (|r_full) | r_valid;

endmodule
